input_conditioner: RTL and testbench

Synchronises and debounces the raw board inputs (16 switches, 5 buttons, 4 input pins) before they reach the memory-mapped peripheral block. It outputs clean, glitch-free levels on the same `sw`/`btn`/`ipin` buses that the peripheral block's digital-input register samples. It also produces one-cycle rise/fall pulses per button for edge-triggered logic. It sits between the FPGA top-level pins and the peripheral block.

---
 rtl/input_conditioner_pkg.sv | 18 +
 rtl/input_conditioner_debounce_bit.sv | 62 ++++++
 rtl/input_conditioner.sv | 87 ++++++++
 tb/tb_input_conditioner.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/input_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// input_conditioner_pkg
// Shared constants for the board-input conditioner and the peripheral block
// that samples its outputs.
//   N_SW / N_BTN / N_IPIN     : widths of the switch, button and input-pin buses
//   N_IN                      : total number of conditioned bits
//   DEFAULT_DEBOUNCE_CYCLES   : 5 ms at 100 MHz
// -----------------------------------------------------------------------------
package input_conditioner_pkg;

    localparam int N_SW  = 16;
    localparam int N_BTN = 5;
    localparam int N_IPIN = 4;
    localparam int N_IN  = N_SW + N_BTN + N_IPIN;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 500_000;

endpackage : input_conditioner_pkg

// File: rtl/input_conditioner_debounce_bit.sv
// -----------------------------------------------------------------------------
// debounce_bit
// Two-flop synchroniser followed by a disagreement counter for one raw input.
// The stable level only moves after DEBOUNCE_CYCLES consecutive synchronised
// samples disagree with it; any agreeing sample discards the count.
// Ports:
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   raw      : raw input, asynchronous to clk
//   stable   : debounced level (registered)
//   changed  : registered strobe, high for the cycle right after stable moved
// -----------------------------------------------------------------------------
module debounce_bit
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable,
    output logic changed
);

    // Terminal count: the disagreement that reaches this value is the last one.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_r;
    logic             s2_r;
    logic             stable_r;
    logic             changed_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchroniser, disagreement counter and stable level update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r      <= 1'b0;
            s2_r      <= 1'b0;
            stable_r  <= 1'b0;
            changed_r <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
        end else begin
            s1_r      <= raw;
            s2_r      <= s1_r;
            changed_r <= 1'b0;
            if (s2_r == stable_r) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (cnt_r == CNT_LAST) begin
                stable_r  <= s2_r;
                changed_r <= 1'b1;
                cnt_r     <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign stable  = stable_r;
    assign changed = changed_r;

endmodule : debounce_bit

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
// Synchronises and debounces the raw switches, buttons and input pins, and
// produces one-cycle rise/fall pulses for each debounced button.
// Ports:
//   clk, rst_n          : system clock, asynchronous active-low reset
//   sw_raw/btn_raw/ipin_raw : raw board inputs (asynchronous)
//   sw/btn/ipin         : debounced levels, straight from stable registers
//   btn_rise/btn_fall   : registered pulses, one cycle after btn changed
// -----------------------------------------------------------------------------
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_SW-1:0]   sw_raw,
    input  logic [N_BTN-1:0]  btn_raw,
    input  logic [N_IPIN-1:0] ipin_raw,
    output logic [N_SW-1:0]   sw,
    output logic [N_BTN-1:0]  btn,
    output logic [N_IPIN-1:0] ipin,
    output logic [N_BTN-1:0]  btn_rise,
    output logic [N_BTN-1:0]  btn_fall
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [N_SW-1:0]   sw_stable_s;
    logic [N_BTN-1:0]  btn_stable_s;
    logic [N_IPIN-1:0] ipin_stable_s;
    logic [N_BTN-1:0]  btn_changed_s;
    // Change strobes of levels that have no edge outputs.
    logic [N_SW-1:0]   sw_changed_unused_s;
    logic [N_IPIN-1:0] ipin_changed_unused_s;
    logic [N_BTN-1:0]  btn_rise_r;
    logic [N_BTN-1:0]  btn_fall_r;

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db (
            .clk     (clk),
            .rst_n   (rst_n),
            .raw     (sw_raw[i]),
            .stable  (sw_stable_s[i]),
            .changed (sw_changed_unused_s[i])
        );
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db (
            .clk     (clk),
            .rst_n   (rst_n),
            .raw     (btn_raw[i]),
            .stable  (btn_stable_s[i]),
            .changed (btn_changed_s[i])
        );
    end

    for (genvar i = 0; i < N_IPIN; i++) begin : g_ipin
        debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db (
            .clk     (clk),
            .rst_n   (rst_n),
            .raw     (ipin_raw[i]),
            .stable  (ipin_stable_s[i]),
            .changed (ipin_changed_unused_s[i])
        );
    end

    // Button edge pulses: the strobe marks a change, the new level gives direction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_rise_r <= {N_BTN{1'b0}};
            btn_fall_r <= {N_BTN{1'b0}};
        end else begin
            btn_rise_r <= btn_changed_s & btn_stable_s;
            btn_fall_r <= btn_changed_s & ~btn_stable_s;
        end
    end

    assign sw       = sw_stable_s;
    assign btn      = btn_stable_s;
    assign ipin     = ipin_stable_s;
    assign btn_rise = btn_rise_r;
    assign btn_fall = btn_fall_r;

endmodule : input_conditioner

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_input_conditioner
// Directed scenarios plus randomised input traffic, checked every cycle
// against a sample-history reference model with DEBOUNCE_CYCLES = 4.
// Model: a bit's debounced level flips at an edge when the raw samples taken
// at the previous edges 2..DC+1 (the synchroniser delay) all disagree with it.
// A pulse follows one edge after each flip.
// -----------------------------------------------------------------------------
module tb_input_conditioner;
    import input_conditioner_pkg::*;

    localparam int DC = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N_SW-1:0]   sw_raw = '0;
    logic [N_BTN-1:0]  btn_raw = '0;
    logic [N_IPIN-1:0] ipin_raw = '0;
    logic [N_SW-1:0]   sw;
    logic [N_BTN-1:0]  btn;
    logic [N_IPIN-1:0] ipin;
    logic [N_BTN-1:0]  btn_rise;
    logic [N_BTN-1:0]  btn_fall;

    input_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw_raw   (sw_raw),
        .btn_raw  (btn_raw),
        .ipin_raw (ipin_raw),
        .sw       (sw),
        .btn      (btn),
        .ipin     (ipin),
        .btn_rise (btn_rise),
        .btn_fall (btn_fall)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state.
    logic [N_IN-1:0]  hist [0:DC+1];   // hist[j] = raw sampled j edges ago
    logic [N_IN-1:0]  m_stable;
    logic [N_IN-1:0]  m_flip;
    logic [N_BTN-1:0] m_rise;
    logic [N_BTN-1:0] m_fall;

    function automatic logic [N_IN-1:0] raw_all();
        return {ipin_raw, btn_raw, sw_raw};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int j = 0; j <= DC + 1; j++) hist[j] = '0;
        m_stable = '0;
        m_flip   = '0;
        m_rise   = '0;
        m_fall   = '0;
    endtask

    task automatic model_edge();
        logic [N_IN-1:0] ones;
        logic [N_IN-1:0] zeros;
        m_rise = m_flip[N_SW +: N_BTN] & m_stable[N_SW +: N_BTN];
        m_fall = m_flip[N_SW +: N_BTN] & ~m_stable[N_SW +: N_BTN];
        for (int j = DC + 1; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = raw_all();
        ones  = '1;
        zeros = '1;
        for (int j = 2; j <= DC + 1; j++) begin
            ones  = ones & hist[j];
            zeros = zeros & ~hist[j];
        end
        m_flip   = (m_stable & zeros) | (~m_stable & ones);
        m_stable = m_stable ^ m_flip;
    endtask

    task automatic check_outputs();
        chk("sw",       32'(sw),       32'(m_stable[N_SW-1:0]));
        chk("btn",      32'(btn),      32'(m_stable[N_SW +: N_BTN]));
        chk("ipin",     32'(ipin),     32'(m_stable[N_SW+N_BTN +: N_IPIN]));
        chk("btn_rise", 32'(btn_rise), 32'(m_rise));
        chk("btn_fall", 32'(btn_fall), 32'(m_fall));
        chk("rise_fall_disjoint", 32'(btn_rise & btn_fall), 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        check_outputs();
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Assert reset now, hold it over some edges, release between edges.
    task automatic do_reset(input int hold);
        rst_n = 1'b0;
        #1;
        model_clear();
        chk("rst_sw",   32'(sw),   32'd0);
        chk("rst_btn",  32'(btn),  32'd0);
        chk("rst_ipin", 32'(ipin), 32'd0);
        chk("rst_rise", 32'(btn_rise), 32'd0);
        chk("rst_fall", 32'(btn_fall), 32'd0);
        for (int i = 0; i < hold; i++) @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int high_cnt;
        int edge_cnt;
        logic prev;
        logic [N_IN-1:0] r;

        // Reset with all raw inputs high.
        sw_raw = '1; btn_raw = '1; ipin_raw = '1;
        do_reset(3);
        step_n(5);
        chk("rst_lat_early", 32'(sw), 32'd0);
        step();
        chk("rst_lat_sw",   32'(sw),   32'hFFFF);
        chk("rst_lat_btn",  32'(btn),  32'h1F);
        chk("rst_lat_ipin", 32'(ipin), 32'hF);
        chk("rst_lat_rise0", 32'(btn_rise), 32'h00);
        step();
        chk("rst_lat_rise", 32'(btn_rise), 32'h1F);
        step();
        chk("rst_lat_rise_end", 32'(btn_rise), 32'h00);

        // Settle everything low.
        sw_raw = '0; btn_raw = '0; ipin_raw = '0;
        step_n(12);

        // Clean press of btn[2].
        btn_raw[2] = 1'b1;
        step_n(5);
        chk("press_early", 32'(btn), 32'h00);
        step();
        chk("press_btn", 32'(btn), 32'h04);
        step();
        chk("press_rise", 32'(btn_rise), 32'h04);
        chk("press_fall", 32'(btn_fall), 32'h00);
        step_n(3);
        btn_raw[2] = 1'b0;
        step_n(10);

        // Three-cycle glitch on sw[7] is rejected.
        sw_raw[7] = 1'b1;
        step_n(3);
        sw_raw[7] = 1'b0;
        high_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (sw[7]) high_cnt++;
        end
        chk("glitch3_high_cycles", 32'(high_cnt), 32'd0);

        // Four-cycle pulse passes as a four-cycle level.
        sw_raw[7] = 1'b1;
        step_n(4);
        sw_raw[7] = 1'b0;
        high_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (sw[7]) high_cnt++;
        end
        chk("glitch4_high_cycles", 32'(high_cnt), 32'd4);

        // Bounce on ipin[0]: 1,0,1,0,1 then hold 1.
        for (int i = 0; i < 4; i++) begin
            ipin_raw[0] = ~ipin_raw[0];
            step();
        end
        ipin_raw[0] = 1'b1;
        edge_cnt = 0;
        prev = ipin[0];
        for (int i = 0; i < 5; i++) begin
            step();
            if (ipin[0] != prev) edge_cnt++;
            prev = ipin[0];
        end
        chk("bounce_early", 32'(ipin[0]), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            if (ipin[0] != prev) edge_cnt++;
            prev = ipin[0];
            if (i == 0) chk("bounce_rise", 32'(ipin[0]), 32'd1);
        end
        chk("bounce_transitions", 32'(edge_cnt), 32'd1);
        ipin_raw[0] = 1'b0;
        step_n(10);

        // Reset while btn[0] is mid-count.
        btn_raw[0] = 1'b1;
        step_n(4);
        do_reset(2);
        step_n(5);
        chk("midrst_early", 32'(btn[0]), 32'd0);
        step();
        chk("midrst_btn", 32'(btn[0]), 32'd1);
        btn_raw[0] = 1'b0;
        step_n(10);

        // All inputs change together.
        r = 25'h1AAAAAA;
        {ipin_raw, btn_raw, sw_raw} = r;
        step_n(5);
        chk("indep_early", 32'(sw), 32'd0);
        step();
        chk("indep_sw",   32'(sw),   32'(r[15:0]));
        chk("indep_btn",  32'(btn),  32'(r[20:16]));
        chk("indep_ipin", 32'(ipin), 32'(r[24:21]));
        step();
        chk("indep_rise", 32'(btn_rise), 32'(r[20:16]));
        chk("indep_fall", 32'(btn_fall), 32'd0);
        r = ~r;
        {ipin_raw, btn_raw, sw_raw} = r;
        step_n(7);

        // Randomised traffic: sparse bit toggles and bursts.
        for (int i = 0; i < 400; i++) begin
            r = raw_all();
            if ($urandom_range(0, 3) == 0)
                r = r ^ N_IN'($urandom & $urandom & $urandom);
            {ipin_raw, btn_raw, sw_raw} = r;
            step();
            if (i == 200) begin
                do_reset($urandom_range(1, 3));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_input_conditioner
